// File: rtl/zloader.sv
// zloader: streams a length-prefixed, XOR-checked program image into a
// 16-entry program RAM, pads the remainder with FILL_BYTE, and holds the CPU
// core in reset until a clean image has been written.
//
// state | meaning
// IDLE  | after reset, waiting for START
// LEN   | accepting the length byte L
// DATA  | accepting L payload bytes, one RAM write each
// CHK   | accepting the checksum byte
// FILL  | padding addresses L..15 with FILL_BYTE
// DONE  | image loaded, CPU released
// ERR   | bad length or checksum, CPU held
module zloader #(
  parameter int              ADDR_W    = 4,
  parameter int              DATA_W    = 8,
  parameter logic [DATA_W-1:0] FILL_BYTE = 8'h00
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic              IN_VALID,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              IN_READY,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_OP,
  output logic [DATA_W-1:0] RAM_DATA_IN,
  output logic              CPU_RESET,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERROR,
  output logic [DATA_W-1:0] CHECKSUM
);

  localparam int DEPTH = 1 << ADDR_W;
  // Counter terminal value: one past the last RAM address, so it never wraps.
  localparam logic [ADDR_W:0] CNT_END = (ADDR_W+1)'(DEPTH);
  localparam logic [DATA_W:0] MAX_LEN = (DATA_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CHK, S_FILL, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [DATA_W-1:0] chk_q, chk_d;
  logic              ram_op_q, ram_op_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;

  logic in_ready;
  logic xfer;
  logic len_ok;
  logic chk_match;

  assign xfer      = IN_VALID && in_ready;
  assign len_ok    = ({1'b0, IN_DATA} != '0) && ({1'b0, IN_DATA} <= MAX_LEN);
  assign chk_match = (IN_DATA == chk_q);

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      chk_q      <= '0;
      ram_op_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      chk_q      <= chk_d;
      ram_op_q   <= ram_op_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (START) state_d = S_LEN;
      S_LEN:  if (xfer) state_d = len_ok ? S_DATA : S_ERR;
      S_DATA: if (xfer && ((cnt_q + 1'b1) == len_q)) state_d = S_CHK;
      S_CHK: begin
        if (xfer) begin
          if (!chk_match)           state_d = S_ERR;
          else if (len_q == CNT_END) state_d = S_DONE;
          else                       state_d = S_FILL;
        end
      end
      S_FILL: if (cnt_q == CNT_END) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: counter, checksum and the one-cycle registered RAM write.
  // The CHK->FILL transition issues the first pad write so that pad writes
  // are visible only while in FILL and DONE starts with RAM_OP low.
  always_comb begin
    cnt_d      = cnt_q;
    len_d      = len_q;
    chk_d      = chk_q;
    ram_op_d   = 1'b0;
    ram_addr_d = '0;
    ram_data_d = '0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (START) begin
          cnt_d = '0;
          len_d = '0;
          chk_d = '0;
        end
      end
      S_LEN: if (xfer) len_d = IN_DATA[ADDR_W:0];
      S_DATA: begin
        if (xfer) begin
          ram_op_d   = 1'b1;
          ram_addr_d = cnt_q[ADDR_W-1:0];
          ram_data_d = IN_DATA;
          chk_d      = chk_q ^ IN_DATA;
          cnt_d      = cnt_q + 1'b1;
        end
      end
      S_CHK: begin
        if (xfer && chk_match && (len_q != CNT_END)) begin
          ram_op_d   = 1'b1;
          ram_addr_d = cnt_q[ADDR_W-1:0];
          ram_data_d = FILL_BYTE;
          cnt_d      = cnt_q + 1'b1;
        end
      end
      S_FILL: begin
        if (cnt_q != CNT_END) begin
          ram_op_d   = 1'b1;
          ram_addr_d = cnt_q[ADDR_W-1:0];
          ram_data_d = FILL_BYTE;
          cnt_d      = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    in_ready    = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
    IN_READY    = in_ready;
    BUSY        = in_ready || (state_q == S_FILL);
    DONE        = (state_q == S_DONE);
    ERROR       = (state_q == S_ERR);
    CPU_RESET   = (state_q != S_DONE);
    CHECKSUM    = chk_q;
    RAM_OP      = ram_op_q;
    RAM_ADDR    = ram_addr_q;
    RAM_DATA_IN = ram_data_q;
  end

endmodule

// File: tb/tb_zloader.sv
// Self-checking bench for zloader: directed scenarios plus randomized sessions
// checked against a model of the load protocol.
module tb_zloader;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       START = 1'b0;
  logic       IN_VALID = 1'b0;
  logic [7:0] IN_DATA = 8'h00;
  logic       IN_READY;
  logic [3:0] RAM_ADDR;
  logic       RAM_OP;
  logic [7:0] RAM_DATA_IN;
  logic       CPU_RESET;
  logic       BUSY;
  logic       DONE;
  logic       ERROR;
  logic [7:0] CHECKSUM;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [7:0] stream[$];
  logic [3:0] wr_a[$];
  logic [7:0] wr_d[$];
  int         wr_c[$];

  zloader #(.ADDR_W(4), .DATA_W(8), .FILL_BYTE(8'h00)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .IN_VALID(IN_VALID),
    .IN_DATA(IN_DATA), .IN_READY(IN_READY), .RAM_ADDR(RAM_ADDR),
    .RAM_OP(RAM_OP), .RAM_DATA_IN(RAM_DATA_IN), .CPU_RESET(CPU_RESET),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .CHECKSUM(CHECKSUM)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Log every RAM write seen by the (imaginary) program RAM.
  always @(negedge CLK) begin
    if (RAM_OP === 1'b1) begin
      wr_a.push_back(RAM_ADDR);
      wr_d.push_back(RAM_DATA_IN);
      wr_c.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 32'(IN_READY), 0);
    check({tag, "_ram_op"}, 32'(RAM_OP), 0);
    check({tag, "_ram_addr"}, 32'(RAM_ADDR), 0);
    check({tag, "_ram_data"}, 32'(RAM_DATA_IN), 0);
    check({tag, "_cpu_reset"}, 32'(CPU_RESET), 1);
    check({tag, "_busy"}, 32'(BUSY), 0);
    check({tag, "_done"}, 32'(DONE), 0);
    check({tag, "_error"}, 32'(ERROR), 0);
    check({tag, "_checksum"}, 32'(CHECKSUM), 0);
  endtask

  task automatic clear_log();
    @(posedge CLK);
    wr_a.delete();
    wr_d.delete();
    wr_c.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0; START = 1'b0; IN_VALID = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  // Drive one byte; returns once it has been accepted (or the bound expires).
  task automatic send_byte(input logic [7:0] b, input int idle, input bit start_noise);
    int k;
    for (int j = 0; j < idle; j++) begin
      IN_VALID = 1'b0; START = start_noise;
      @(negedge CLK);
    end
    IN_VALID = 1'b1; IN_DATA = b; START = start_noise;
    k = 0;
    while (IN_READY !== 1'b1 && k < 20) begin
      @(negedge CLK);
      k++;
    end
    if (k == 20) check("ready_timeout", 0, 1);
    @(negedge CLK);
    IN_VALID = 1'b0; START = 1'b0;
  endtask

  // stall: 0 = back-to-back, 1 = one idle cycle before every byte, 2 = random 0..2
  task automatic run_session(input string tag, input int stall, input bit start_noise);
    int         l;
    bit         len_ok, exp_ok;
    logic [7:0] x;
    int         n_send, k;
    logic [3:0] ea[$];
    logic [7:0] ed[$];

    l = int'(stream[0]);
    len_ok = (l >= 1) && (l <= 16);
    x = 8'h00;
    exp_ok = 1'b0;
    if (len_ok) begin
      for (int i = 1; i <= l; i++) x = x ^ stream[i];
      exp_ok = (stream[l+1] == x);
      for (int i = 0; i < l; i++) begin ea.push_back(4'(i)); ed.push_back(stream[i+1]); end
      if (exp_ok) for (int a = l; a < 16; a++) begin ea.push_back(4'(a)); ed.push_back(8'h00); end
    end
    n_send = len_ok ? l + 2 : 1;

    clear_log();
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int i = 0; i < n_send; i++)
      send_byte(stream[i], (stall == 2) ? int'($urandom_range(0, 2)) : stall, start_noise);

    k = 0;
    while (DONE !== 1'b1 && ERROR !== 1'b1 && k < 40) begin
      @(negedge CLK);
      k++;
    end
    if (k == 40) check({tag, "_end_timeout"}, 0, 1);
    @(negedge CLK);
    @(negedge CLK);

    check({tag, "_done"}, 32'(DONE), 32'(exp_ok));
    check({tag, "_error"}, 32'(ERROR), 32'(!exp_ok));
    check({tag, "_cpu_reset"}, 32'(CPU_RESET), 32'(!exp_ok));
    check({tag, "_busy"}, 32'(BUSY), 0);
    check({tag, "_in_ready"}, 32'(IN_READY), 0);
    check({tag, "_ram_op_idle"}, 32'(RAM_OP), 0);
    check({tag, "_checksum"}, 32'(CHECKSUM), 32'(len_ok ? x : 8'h00));
    check({tag, "_write_count"}, 32'(wr_a.size()), 32'(ea.size()));
    if (wr_a.size() == ea.size()) begin
      for (int i = 0; i < ea.size(); i++) begin
        check({tag, "_wr_addr"}, 32'(wr_a[i]), 32'(ea[i]));
        check({tag, "_wr_data"}, 32'(wr_d[i]), 32'(ed[i]));
      end
      if (exp_ok)
        for (int i = l + 1; i < ea.size(); i++)
          check({tag, "_fill_back_to_back"}, 32'(wr_c[i] - wr_c[i-1]), 1);
    end
  endtask

  initial begin
    int l;
    logic [7:0] x;

    // Reset state, with START and IN_VALID asserted to show reset priority.
    START = 1'b1; IN_VALID = 1'b1; IN_DATA = 8'h05;
    @(negedge CLK);
    @(negedge CLK);
    check_idle("reset");
    START = 1'b0; IN_VALID = 1'b0;
    RESET_N = 1'b1;
    @(negedge CLK);

    // Short image with padding.
    stream = '{8'h03, 8'h41, 8'h82, 8'hC3, 8'h00};
    run_session("len3", 0, 1'b0);

    // Full image, no padding.
    stream = '{8'h10};
    for (int i = 1; i <= 16; i++) stream.push_back(8'(i));
    stream.push_back(8'h10);
    run_session("len16", 0, 1'b0);

    // Bad checksum, then restart clears ERROR.
    stream = '{8'h02, 8'h11, 8'h22, 8'h00};
    run_session("badchk", 0, 1'b0);
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check("restart_error", 32'(ERROR), 0);
    check("restart_busy", 32'(BUSY), 1);
    check("restart_in_ready", 32'(IN_READY), 1);
    check("restart_cpu_reset", 32'(CPU_RESET), 1);
    check("restart_checksum", 32'(CHECKSUM), 0);
    do_reset();

    // Illegal lengths.
    stream = '{8'h00};
    run_session("len0", 0, 1'b0);
    stream = '{8'h11};
    run_session("len17", 0, 1'b0);

    // Stalled payload with START noise during the session.
    stream = '{8'h03, 8'h41, 8'h82, 8'hC3, 8'h00};
    run_session("stall", 1, 1'b1);

    // Reset in the middle of DATA after one write.
    clear_log();
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    send_byte(8'h05, 0, 1'b0);
    send_byte(8'hAA, 0, 1'b0);
    check("midrst_write_seen", 32'(RAM_OP), 1);
    RESET_N = 1'b0; START = 1'b1; IN_VALID = 1'b1; IN_DATA = 8'h55;
    @(negedge CLK);
    check_idle("midrst");
    @(negedge CLK);
    check("midrst_hold_busy", 32'(BUSY), 0);
    check("midrst_hold_ram_op", 32'(RAM_OP), 0);
    RESET_N = 1'b1; START = 1'b0; IN_VALID = 1'b0;
    check("midrst_write_count", 32'(wr_a.size()), 1);
    @(negedge CLK);
    check("midrst_idle_ready", 32'(IN_READY), 0);

    // Randomized sessions.
    for (int s = 0; s < 30; s++) begin
      if ($urandom_range(0, 4) != 0) l = int'($urandom_range(1, 16));
      else l = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(17, 255));
      stream = '{8'(l)};
      x = 8'h00;
      if (l >= 1 && l <= 16) begin
        for (int i = 0; i < l; i++) begin
          stream.push_back(8'($urandom));
          x = x ^ stream[i+1];
        end
        if ($urandom_range(0, 3) != 0) stream.push_back(x);
        else stream.push_back(x ^ 8'($urandom_range(1, 255)));
      end
      run_session("rand", 2, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/zloader.md
ZLOADER -- requirements
Module: zloader

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning program RAM address width (16 locations).
REQ-002 SHALL have parameter DATA_W, default 8, meaning instruction/byte width.
REQ-003 SHALL have parameter FILL_BYTE, default 8'h00, meaning value written to unloaded locations (NOP).
REQ-004 SHALL have port CLK  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port RESET_N  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port START  input  1  begin a load session when idle, done or in error.
REQ-007 SHALL have port IN_VALID  input  1  upstream byte present.
REQ-008 SHALL have port IN_DATA  input  DATA_W  upstream byte.
REQ-009 SHALL have port IN_READY  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port RAM_ADDR  output  ADDR_W  program RAM address.
REQ-011 SHALL have port RAM_OP  output  1  RAM opcode; 1 = write, 0 = read.
REQ-012 SHALL have port RAM_DATA_IN  output  DATA_W  RAM write data.
REQ-013 SHALL have port CPU_RESET  output  1  active-high hold on the CPU core.
REQ-014 SHALL have ports BUSY, DONE, ERROR  output  1 each  session status.
REQ-015 SHALL have port CHECKSUM  output  DATA_W  running XOR of accepted payload bytes.

Function
REQ-016 SHALL implement states IDLE, LEN, DATA, CHK, FILL, DONE, ERR, all registered.
REQ-017 SHALL transfer a byte only on a rising edge with IN_VALID=1 and IN_READY=1; IN_READY SHALL be 1 exactly in LEN, DATA, CHK.
REQ-018 SHALL move IDLE/DONE/ERR -> LEN on START=1, clearing CHECKSUM, DONE, ERROR and the address counter, and raising CPU_RESET; START in LEN/DATA/CHK/FILL SHALL be ignored.
REQ-019 In LEN, SHALL accept the length byte L; L in 1..16 -> DATA with count=L; L=0 or L>16 -> ERR.
REQ-020 In DATA, each accepted byte SHALL register RAM_ADDR=counter, RAM_DATA_IN=byte, RAM_OP=1 for exactly the next cycle, XOR into CHECKSUM, and increment counter; after the L-th byte -> CHK.
REQ-021 RAM_OP SHALL be 0 in any cycle following no write request (stalls with IN_VALID=0 produce no writes).
REQ-022 In CHK, SHALL accept one byte; equal to CHECKSUM -> FILL if L<16, else DONE; unequal -> ERR with no further RAM writes.
REQ-023 In FILL, SHALL write FILL_BYTE to addresses L..15, one per cycle, back-to-back, then -> DONE; counter SHALL not wrap past 15.
REQ-024 In DONE, SHALL hold DONE=1, CPU_RESET=0, RAM_OP=0, RAM_ADDR=0.
REQ-025 In ERR, SHALL hold ERROR=1, CPU_RESET=1, RAM_OP=0 until START or reset.
REQ-026 BUSY SHALL be 1 exactly in LEN, DATA, CHK, FILL.
REQ-027 CPU_RESET SHALL be 1 in every state except DONE.
REQ-028 CHECKSUM SHALL remain readable and unchanged in DONE and ERR.

Reset
REQ-029 On a rising CLK with RESET_N=0, SHALL enter IDLE with IN_READY=0, RAM_OP=0, RAM_ADDR=0, RAM_DATA_IN=0, CPU_RESET=1, BUSY=0, DONE=0, ERROR=0, CHECKSUM=0, counter=0.
REQ-030 RESET_N=0 mid-session (any state) SHALL abort with no further RAM write after the reset edge; RESET_N SHALL take priority over START and IN_VALID.

Verification
REQ-031 START, stream 03,41,82,C3,checksum 00 -> writes 41@0,82@1,C3@2, then 00@3..00@15 on consecutive cycles, DONE=1, CPU_RESET=0, CHECKSUM=00.
REQ-032 START, L=16, bytes 01..10, checksum 10 -> 16 writes, no FILL cycles, DONE=1.
REQ-033 START, 02,11,22,checksum 00 (expected 33) -> two writes only, ERROR=1, CPU_RESET=1; START again -> LEN, ERROR=0.
REQ-034 L=00 and L=11 (17) -> ERR immediately, zero RAM writes.
REQ-035 Payload with IN_VALID toggling 1/0 each cycle -> RAM_OP=0 on stall cycles, identical final RAM contents to REQ-031.
REQ-036 RESET_N=0 during DATA after one write -> next cycle IDLE, RAM_OP=0, CPU_RESET=1, all status 0.
